// File: rtl/rs_pkg.sv
// Shared types and constants for the multi-entry reservation station.
// Tag and opcode widths come from `ROB_SIZE and `ALU_OP_WIDTH (defaulted below if absent).
`ifndef ROB_SIZE
`define ROB_SIZE 5
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

package rs_pkg;
  localparam int RS_XLEN  = 32;
  localparam int RS_TAG_W = `ROB_SIZE;
  localparam int RS_OP_W  = `ALU_OP_WIDTH;

  localparam logic [RS_OP_W-1:0] ALU_OP_ADD = RS_OP_W'(0);
  localparam logic [RS_OP_W-1:0] ALU_OP_SUB = RS_OP_W'(1);
  localparam logic [RS_OP_W-1:0] ALU_OP_AND = RS_OP_W'(2);
  localparam logic [RS_OP_W-1:0] ALU_OP_OR  = RS_OP_W'(3);
  localparam logic [RS_OP_W-1:0] ALU_OP_XOR = RS_OP_W'(4);
  localparam logic [RS_OP_W-1:0] ALU_OP_SLL = RS_OP_W'(5);
  localparam logic [RS_OP_W-1:0] ALU_OP_SRL = RS_OP_W'(6);
  localparam logic [RS_OP_W-1:0] ALU_OP_SLT = RS_OP_W'(7);

  typedef struct packed {
    logic                en;
    logic [RS_OP_W-1:0]  op;
    logic [RS_TAG_W-1:0] tag;
    logic [RS_XLEN-1:0]  v1;
    logic                v1_rdy;
    logic [RS_TAG_W-1:0] q1;
    logic [RS_XLEN-1:0]  v2;
    logic                v2_rdy;
    logic [RS_TAG_W-1:0] q2;
  } rs_issue_t;

  typedef struct packed {
    logic                valid;
    logic [RS_TAG_W-1:0] tag;
    logic [RS_XLEN-1:0]  value;
  } rs_cdb_t;

  typedef struct packed {
    logic [RS_OP_W-1:0]  op;
    logic [RS_XLEN-1:0]  v1;
    logic [RS_XLEN-1:0]  v2;
    logic [RS_TAG_W-1:0] tag;
    logic                valid;
  } rs_disp_t;

  typedef struct packed {
    logic                busy;
    logic [RS_OP_W-1:0]  op;
    logic [RS_TAG_W-1:0] tag;
    logic [RS_XLEN-1:0]  v1;
    logic                v1_rdy;
    logic [RS_TAG_W-1:0] q1;
    logic [RS_XLEN-1:0]  v2;
    logic                v2_rdy;
    logic [RS_TAG_W-1:0] q2;
  } rs_entry_t;
endpackage

// File: rtl/rs_age_select.sv
// Age matrix over ENTRIES slots and a one-hot grant of the oldest eligible slot.
// age_reg[i][j]=1 means slot i was allocated before slot j.
module rs_age_select #(
  parameter int ENTRIES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [ENTRIES-1:0] alloc_oh,
  input  logic [ENTRIES-1:0] free_oh,
  input  logic [ENTRIES-1:0] elig,
  output logic [ENTRIES-1:0] grant
);
  logic [ENTRIES-1:0][ENTRIES-1:0] age_reg;
  logic [ENTRIES-1:0][ENTRIES-1:0] older;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_reg <= '0;
    end else if (flush) begin
      age_reg <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        for (int j = 0; j < ENTRIES; j++) begin
          // A new slot is younger than everything already present.
          if (alloc_oh[i])
            age_reg[i][j] <= 1'b0;
          else if (alloc_oh[j])
            age_reg[i][j] <= 1'b1;
          else if (free_oh[i] | free_oh[j])
            age_reg[i][j] <= 1'b0;
        end
      end
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_grant
      for (gj = 0; gj < ENTRIES; gj++) begin : g_col
        assign older[gi][gj] = age_reg[gj][gi];
      end
      assign grant[gi] = elig[gi] & ~|(elig & older[gi]);
    end
  endgenerate
endmodule

// File: rtl/reservation_station_multi.sv
// ENTRIES-slot reservation station with CDB wakeup and age-ordered dispatch to one ALU.
// Optional: define RS_CDB_SELECT_BYPASS_EN to let a CDB hit make a slot eligible the same cycle.
module reservation_station_multi
  import rs_pkg::*;
#(
  parameter int XLEN    = RS_XLEN,
  parameter int TAG_W   = RS_TAG_W,
  parameter int OP_W    = RS_OP_W,
  parameter int ENTRIES = 4,
  localparam int CW     = $clog2(ENTRIES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             issue_en,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [XLEN-1:0]  issue_v1,
  input  logic [XLEN-1:0]  issue_v2,
  input  logic             issue_v1_rdy,
  input  logic             issue_v2_rdy,
  input  logic [TAG_W-1:0] issue_q1,
  input  logic [TAG_W-1:0] issue_q2,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_value,
  input  logic             alu_en,
  output logic             disp_valid_o,
  output logic [OP_W-1:0]  disp_op_o,
  output logic [XLEN-1:0]  disp_v1_o,
  output logic [XLEN-1:0]  disp_v2_o,
  output logic [TAG_W-1:0] disp_tag_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);
  logic [ENTRIES-1:0] busy_reg, v1_rdy_reg, v2_rdy_reg;
  logic [OP_W-1:0]    op_reg  [ENTRIES];
  logic [TAG_W-1:0]   tag_reg [ENTRIES];
  logic [TAG_W-1:0]   q1_reg  [ENTRIES];
  logic [TAG_W-1:0]   q2_reg  [ENTRIES];
  logic [XLEN-1:0]    v1_reg  [ENTRIES];
  logic [XLEN-1:0]    v2_reg  [ENTRIES];

  logic               full_reg;
  logic [CW-1:0]      count_reg;
  logic               disp_valid_reg;
  logic [OP_W-1:0]    disp_op_reg;
  logic [XLEN-1:0]    disp_v1_reg, disp_v2_reg;
  logic [TAG_W-1:0]   disp_tag_reg;

  logic               issue_go, select_go, cap1, cap2;
  logic [ENTRIES-1:0] alloc_oh, grant_oh, wake1, wake2, elig, busy_next;
  logic [OP_W-1:0]    sel_op;
  logic [XLEN-1:0]    sel_v1, sel_v2;
  logic [TAG_W-1:0]   sel_tag;

  assign issue_go  = issue_en & ~stall_i & ~flush_i & ~full_reg;
  assign select_go = alu_en & ~stall_i & ~flush_i;
  // Lowest clear bit of busy_reg.
  assign alloc_oh  = issue_go ? (~busy_reg & (busy_reg + ENTRIES'(1))) : '0;
  assign cap1      = ~issue_v1_rdy & cdb_valid & (cdb_tag == issue_q1);
  assign cap2      = ~issue_v2_rdy & cdb_valid & (cdb_tag == issue_q2);

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_slot
      assign wake1[gi] = busy_reg[gi] & ~v1_rdy_reg[gi] & cdb_valid & (q1_reg[gi] == cdb_tag);
      assign wake2[gi] = busy_reg[gi] & ~v2_rdy_reg[gi] & cdb_valid & (q2_reg[gi] == cdb_tag);
`ifdef RS_CDB_SELECT_BYPASS_EN
      assign elig[gi] = select_go & busy_reg[gi] & (v1_rdy_reg[gi] | wake1[gi])
                                                 & (v2_rdy_reg[gi] | wake2[gi]);
`else
      assign elig[gi] = select_go & busy_reg[gi] & v1_rdy_reg[gi] & v2_rdy_reg[gi];
`endif
      assign busy_next[gi] = ~flush_i & ((busy_reg[gi] & ~grant_oh[gi]) | alloc_oh[gi]);
    end
  endgenerate

  rs_age_select #(.ENTRIES(ENTRIES)) u_age_select (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush_i),
    .alloc_oh (alloc_oh),
    .free_oh  (grant_oh),
    .elig     (elig),
    .grant    (grant_oh)
  );

  // An operand not yet marked ready can only be selected via the CDB bypass.
  always_comb begin
    sel_op  = '0;
    sel_tag = '0;
    sel_v1  = '0;
    sel_v2  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (grant_oh[i]) begin
        sel_op  = op_reg[i];
        sel_tag = tag_reg[i];
        sel_v1  = v1_rdy_reg[i] ? v1_reg[i] : cdb_value;
        sel_v2  = v2_rdy_reg[i] ? v2_reg[i] : cdb_value;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg   <= '0;
      v1_rdy_reg <= '0;
      v2_rdy_reg <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_reg[i]  <= '0;
        tag_reg[i] <= '0;
        q1_reg[i]  <= '0;
        q2_reg[i]  <= '0;
        v1_reg[i]  <= '0;
        v2_reg[i]  <= '0;
      end
    end else begin
      busy_reg <= busy_next;
      if (!flush_i) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (alloc_oh[i]) begin
            op_reg[i]     <= issue_op;
            tag_reg[i]    <= issue_tag;
            q1_reg[i]     <= issue_q1;
            q2_reg[i]     <= issue_q2;
            v1_reg[i]     <= issue_v1_rdy ? issue_v1 : cdb_value;
            v2_reg[i]     <= issue_v2_rdy ? issue_v2 : cdb_value;
            v1_rdy_reg[i] <= issue_v1_rdy | cap1;
            v2_rdy_reg[i] <= issue_v2_rdy | cap2;
          end else begin
            if (wake1[i]) begin
              v1_reg[i]     <= cdb_value;
              v1_rdy_reg[i] <= 1'b1;
            end
            if (wake2[i]) begin
              v2_reg[i]     <= cdb_value;
              v2_rdy_reg[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_valid_reg <= 1'b0;
      disp_op_reg    <= '0;
      disp_v1_reg    <= '0;
      disp_v2_reg    <= '0;
      disp_tag_reg   <= '0;
      count_reg      <= '0;
      full_reg       <= 1'b0;
    end else begin
      disp_valid_reg <= |grant_oh;
      if (|grant_oh) begin
        disp_op_reg  <= sel_op;
        disp_v1_reg  <= sel_v1;
        disp_v2_reg  <= sel_v2;
        disp_tag_reg <= sel_tag;
      end
      count_reg <= CW'($countones(busy_next));
      full_reg  <= &busy_next;
    end
  end

  assign disp_valid_o = disp_valid_reg;
  assign disp_op_o    = disp_op_reg;
  assign disp_v1_o    = disp_v1_reg;
  assign disp_v2_o    = disp_v2_reg;
  assign disp_tag_o   = disp_tag_reg;
  assign full_o       = full_reg;
  assign count_o      = count_reg;
endmodule

// File: tb/tb_reservation_station_multi.sv
// Directed plus random stimulus against a sequence-number reference model of the station.
// Also models the RS_CDB_SELECT_BYPASS_EN variant when that macro is defined.
module tb_reservation_station_multi;
  import rs_pkg::*;
  localparam int XLEN = RS_XLEN, TAG_W = RS_TAG_W, OP_W = RS_OP_W, E = 4;
  localparam int CW = $clog2(E + 1);

  logic clk = 1'b0, rst = 1'b0;
  logic stall_i = 0, flush_i = 0, issue_en = 0, alu_en = 0, cdb_valid = 0;
  logic issue_v1_rdy = 0, issue_v2_rdy = 0;
  logic [OP_W-1:0]  issue_op = '0;
  logic [TAG_W-1:0] issue_tag = '0, issue_q1 = '0, issue_q2 = '0, cdb_tag = '0;
  logic [XLEN-1:0]  issue_v1 = '0, issue_v2 = '0, cdb_value = '0;
  logic             disp_valid_o, full_o;
  logic [OP_W-1:0]  disp_op_o;
  logic [XLEN-1:0]  disp_v1_o, disp_v2_o;
  logic [TAG_W-1:0] disp_tag_o;
  logic [CW-1:0]    count_o;

  reservation_station_multi #(.XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W), .ENTRIES(E)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .issue_en(issue_en), .issue_op(issue_op), .issue_tag(issue_tag),
    .issue_v1(issue_v1), .issue_v2(issue_v2),
    .issue_v1_rdy(issue_v1_rdy), .issue_v2_rdy(issue_v2_rdy),
    .issue_q1(issue_q1), .issue_q2(issue_q2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .alu_en(alu_en),
    .disp_valid_o(disp_valid_o), .disp_op_o(disp_op_o), .disp_v1_o(disp_v1_o),
    .disp_v2_o(disp_v2_o), .disp_tag_o(disp_tag_o), .full_o(full_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: slot contents plus an issue sequence number for age.
  bit               m_busy [E];
  bit               m_r1 [E], m_r2 [E];
  int unsigned      m_seq [E];
  logic [OP_W-1:0]  m_op [E];
  logic [TAG_W-1:0] m_tag [E], m_q1 [E], m_q2 [E];
  logic [XLEN-1:0]  m_v1 [E], m_v2 [E];
  int unsigned      seq_ctr = 0;
  bit               m_dv = 0;
  logic [OP_W-1:0]  m_dop = '0;
  logic [XLEN-1:0]  m_dv1 = '0, m_dv2 = '0;
  logic [TAG_W-1:0] m_dtag = '0;

  task automatic model_step();
    int sel = -1, ifree = -1;
    bit full_pre = 1, h1, h2, ok;
    for (int i = E - 1; i >= 0; i--)
      if (!m_busy[i]) begin full_pre = 0; ifree = i; end
    if (flush_i) begin
      for (int i = 0; i < E; i++) m_busy[i] = 0;
      m_dv = 0;
      return;
    end
    if (alu_en && !stall_i)
      for (int i = 0; i < E; i++) begin
        h1 = cdb_valid && m_q1[i] == cdb_tag;
        h2 = cdb_valid && m_q2[i] == cdb_tag;
`ifdef RS_CDB_SELECT_BYPASS_EN
        ok = m_busy[i] && (m_r1[i] || h1) && (m_r2[i] || h2);
`else
        ok = m_busy[i] && m_r1[i] && m_r2[i];
`endif
        if (ok && (sel < 0 || m_seq[i] < m_seq[sel])) sel = i;
      end
    m_dv = (sel >= 0);
    if (sel >= 0) begin
      m_dop  = m_op[sel];
      m_dtag = m_tag[sel];
      m_dv1  = m_r1[sel] ? m_v1[sel] : cdb_value;
      m_dv2  = m_r2[sel] ? m_v2[sel] : cdb_value;
    end
    for (int i = 0; i < E; i++)
      if (m_busy[i] && cdb_valid) begin
        if (!m_r1[i] && m_q1[i] == cdb_tag) begin m_r1[i] = 1; m_v1[i] = cdb_value; end
        if (!m_r2[i] && m_q2[i] == cdb_tag) begin m_r2[i] = 1; m_v2[i] = cdb_value; end
      end
    if (sel >= 0) m_busy[sel] = 0;
    if (issue_en && !stall_i && !full_pre) begin
      m_busy[ifree] = 1;
      m_seq[ifree]  = seq_ctr++;
      m_op[ifree]   = issue_op;
      m_tag[ifree]  = issue_tag;
      m_q1[ifree]   = issue_q1;
      m_q2[ifree]   = issue_q2;
      m_r1[ifree]   = issue_v1_rdy || (cdb_valid && cdb_tag == issue_q1);
      m_r2[ifree]   = issue_v2_rdy || (cdb_valid && cdb_tag == issue_q2);
      m_v1[ifree]   = issue_v1_rdy ? issue_v1 : cdb_value;
      m_v2[ifree]   = issue_v2_rdy ? issue_v2 : cdb_value;
    end
  endtask

  task automatic cycle();
    int cnt = 0;
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < E; i++) cnt += int'(m_busy[i]);
    check_eq("disp_valid", disp_valid_o, m_dv);
    check_eq("disp_op", disp_op_o, m_dop);
    check_eq("disp_tag", disp_tag_o, m_dtag);
    check_eq("disp_v1", disp_v1_o, m_dv1);
    check_eq("disp_v2", disp_v2_o, m_dv2);
    check_eq("count", count_o, cnt);
    check_eq("full", full_o, cnt == E);
    if (disp_valid_o)
      $display("DISP tag=%0d op=%0d v1=%0h v2=%0h", disp_tag_o, disp_op_o, disp_v1_o, disp_v2_o);
  endtask

  task automatic idle();
    issue_en = 0; cdb_valid = 0; stall_i = 0; flush_i = 0;
  endtask

  task automatic issue(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] v1, input bit r1,
                       input logic [TAG_W-1:0] q1, input logic [XLEN-1:0] v2, input bit r2,
                       input logic [TAG_W-1:0] q2);
    issue_en = 1; issue_op = ALU_OP_ADD; issue_tag = tag;
    issue_v1 = v1; issue_v1_rdy = r1; issue_q1 = q1;
    issue_v2 = v2; issue_v2_rdy = r2; issue_q2 = q2;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
    cdb_valid = 1; cdb_tag = tag; cdb_value = val;
  endtask

  initial begin
    for (int i = 0; i < E; i++) begin
      m_busy[i] = 0; m_r1[i] = 0; m_r2[i] = 0; m_seq[i] = 0; m_op[i] = '0;
      m_tag[i] = '0; m_q1[i] = '0; m_q2[i] = '0; m_v1[i] = '0; m_v2[i] = '0;
    end
    // Drive garbage during reset: outputs must stay at their reset values.
    issue_en = 1; alu_en = 1; issue_v1_rdy = 1; issue_v2_rdy = 1; issue_tag = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", disp_valid_o, 0);
    check_eq("rst_tag", disp_tag_o, 0);
    check_eq("rst_v1", disp_v1_o, 0);
    check_eq("rst_count", count_o, 0);
    check_eq("rst_full", full_o, 0);
    idle(); alu_en = 1;
    rst = 1;

    // Late CDB wakes v2 of tag 10.
    issue(10, 256, 1, 0, 0, 0, 12); cycle();
    idle(); cycle();
    cdb(12, 16); cycle();
    idle(); repeat (3) cycle();

    // Capture at issue time.
    issue(3, 1, 1, 0, 0, 0, 7); cdb(7, 5); cycle();
    idle(); repeat (3) cycle();

    // Fill, overflow drop, then drain in order.
    alu_en = 0;
    for (int t = 1; t <= 5; t++) begin issue(t, t, 1, 0, t * 2, 1, 0); cycle(); end
    idle(); cycle();
    alu_en = 1; repeat (6) cycle();

    // Oldest eligible rather than oldest.
    issue(5, 0, 0, 9, 55, 1, 0); cycle();
    issue(6, 66, 1, 0, 67, 1, 0); cycle();
    idle(); cdb(9, 99); cycle();
    idle(); repeat (4) cycle();

    // Stall with a ready slot and a CDB hit on another.
    alu_en = 0;
    issue(11, 1, 1, 0, 2, 1, 0); cycle();
    issue(12, 0, 0, 4, 3, 1, 0); cycle();
    idle(); alu_en = 1; stall_i = 1; cdb(4, 44); cycle();
    cdb_valid = 0; repeat (2) cycle();
    stall_i = 0; repeat (4) cycle();

    // Flush with pending work, then reissue.
    alu_en = 0;
    for (int t = 20; t < 23; t++) begin issue(t, t, 1, 0, t, 1, 0); cycle(); end
    idle(); alu_en = 1; flush_i = 1; cycle();
    idle(); issue(30, 7, 1, 0, 8, 1, 0); cycle();
    idle(); repeat (3) cycle();

    // Random phase: small tag space so CDB hits and dual matches are frequent.
    for (int n = 0; n < 2000; n++) begin
      issue_en     = ($urandom_range(0, 99) < 60);
      issue_op     = OP_W'($urandom_range(0, 7));
      issue_tag    = TAG_W'($urandom_range(0, 15));
      issue_v1     = $urandom;
      issue_v2     = $urandom;
      issue_v1_rdy = ($urandom_range(0, 1) == 1);
      issue_v2_rdy = ($urandom_range(0, 1) == 1);
      issue_q1     = TAG_W'($urandom_range(0, 7));
      issue_q2     = TAG_W'($urandom_range(0, 7));
      cdb_valid    = ($urandom_range(0, 1) == 1);
      cdb_tag      = TAG_W'($urandom_range(0, 7));
      cdb_value    = $urandom;
      alu_en       = ($urandom_range(0, 99) < (n < 1000 ? 70 : 30));
      stall_i      = ($urandom_range(0, 99) < 10);
      flush_i      = ($urandom_range(0, 99) < 3);
      cycle();
    end
    idle(); alu_en = 1; repeat (5) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reservation_station_multi.md
Name: reservation_station_multi

Overview:
- Parametrised successor to the single-entry reservation station: ENTRIES slots sit in front of one ALU.
- Accepts one issued op per cycle and snoops the CDB to wake pending operands.
- Dispatches the oldest fully-ready entry to the ALU through a registered output stage.
- Adds age ordering, flush and explicit dispatch-ready handshake.

Parameters:
XLEN, 32, operand/value width
TAG_W, `ROB_SIZE, ROB tag width (issue tag, q1/q2, cdb_tag)
OP_W, `ALU_OP_WIDTH, ALU opcode width
ENTRIES, 4, number of slots (2..16)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
stall_i  in  1  freezes issue and dispatch (CDB capture continues)
flush_i  in  1  kill all entries and pending dispatch
issue_en  in  1  issue request
issue_op  in  OP_W  opcode
issue_tag  in  TAG_W  destination ROB tag
issue_v1 / issue_v2  in  XLEN  operand values
issue_v1_rdy / issue_v2_rdy  in  1  operand valid
issue_q1 / issue_q2  in  TAG_W  producer tag when not ready
cdb_valid  in  1  broadcast valid
cdb_tag  in  TAG_W  broadcast tag
cdb_value  in  XLEN  broadcast value
alu_en  in  1  ALU can accept a dispatch this cycle
disp_valid_o  out  1  dispatch valid (registered)
disp_op_o  out  OP_W
disp_v1_o / disp_v2_o  out  XLEN
disp_tag_o  out  TAG_W
full_o  out  1  all entries busy (registered state)
count_o  out  $clog2(ENTRIES+1)  busy entry count

Behaviour:
- Reset (rst=0, async): all busy=0, the age matrix is cleared, every disp_* output is 0, full_o=0 and count_o=0.
- Issue:
  - Accepted iff issue_en & !stall_i & !flush_i & !full_o.
  - The op is written to the lowest-index free slot; issue while full_o=1 is silently dropped.
  - A freeing dispatch does not open a slot until the next cycle.
- Issue-time capture: if operand n is not ready and cdb_valid & cdb_tag==issue_qn in the same cycle, the slot stores cdb_value with rdy=1.
- Wakeup: every busy slot with vn_rdy=0 & cdb_valid & qn==cdb_tag latches cdb_value and sets vn_rdy=1. Wakeup ignores stall_i.
- Eligible slot: busy & v1_rdy & v2_rdy, using registered state.
- Select: when alu_en & !stall_i & !flush_i, pick the oldest eligible slot by age matrix (the slot issued earlier wins). Ties are impossible.
- Dispatch timing:
  - Next cycle: disp_* carry the selected slot, disp_valid_o=1, and that slot's busy clears.
  - With no selection: disp_valid_o=0 and the data outputs hold their last value.
  - Latency: issue with both operands ready at cycle N, dispatch valid at N+2. A CDB wakeup at N also gives dispatch valid at N+2.
- stall_i=1:
  - No issue and no select.
  - disp_valid_o is forced to 0 on the next edge; the data outputs hold.
- flush_i=1: on the next edge all busy=0, disp_valid_o=0, count_o=0 and the age matrix is cleared. Flush has priority over issue, select and wakeup.
- count_o = popcount(busy); full_o = (count==ENTRIES). Both are registered, so they update on the edge after issue/dispatch. Simultaneous issue and dispatch keeps count unchanged.
- A tag matching both q1 and q2 wakes both operands in the same cycle.

Optional Feature:
RS_CDB_SELECT_BYPASS_EN
- Defined: a slot missing exactly the operand(s) matching the current CDB tag is also eligible this cycle. cdb_value is muxed into the dispatch register, so wakeup-to-dispatch drops from N+2 to N+1.
- Undefined: eligibility uses registered rdy bits only, as specified above.

Decomposition:
- Shared package rs_pkg:
  - rs_issue_t (issue fields)
  - rs_cdb_t (valid/tag/value)
  - rs_disp_t (op/v1/v2/tag/valid)
  - rs_entry_t (busy, op, tag, v1, v1_rdy, q1, v2, v2_rdy, q2)
  - the ALU_OP_* constants
- Sub-module rs_age_select (ENTRIES): age matrix update on alloc/free/flush, plus a one-hot oldest-eligible grant.

Test Plan:
- Reset, then issue ADD tag=10 v1=256 rdy, v2 not rdy q2=12; CDB tag=12 value=16 two cycles later -> disp_valid_o one pulse, v1=256, v2=16, tag=10.
- Issue ADD tag=3 v2 q2=7 with cdb_valid tag=7 value=5 in the same cycle -> slot captures 5; dispatch at N+2 with v2=5.
- Fill all 4 slots (tags 1..4, all ready, alu_en=0) -> full_o=1, count_o=4; 5th issue dropped; raise alu_en -> dispatch order 1,2,3,4; full_o drops after the first dispatch.
- Issue tags 5 (waits on q1=9) then 6 (ready); CDB tag=9 -> tag 6 dispatches first, then 5 (oldest *eligible*).
- stall_i held 3 cycles with a ready slot and a CDB hit on another slot -> no dispatch; the stalled slot's rdy bit is set; dispatches resume after stall drops.
- flush_i with 3 busy slots and a pending select -> next cycle count_o=0, disp_valid_o=0, full_o=0; a subsequent issue lands in slot 0.
